sd_slot_arbiter: RTL and testbench

Shares the single user_io SD-sector channel (LBA, per-slot rd/wr, ack, 512-byte buffer port) between two block-level clients: client 0 is the MMC emulation (`sd_card`, image slot 0) and client 1 is the image-slot-1 client (NVRAM/CMOS save-restore). The block sits between the clients and `user_io` in the top level, on `clk_sys`. It:
- latches the winning client's command;
- drives the one-hot slot bit toward `user_io`;
- steers ack, buffer write strobe and buffer read data to the granted client only;
- aborts transfers the ARM side never answers.

---
 rtl/sd_arb_pkg.sv | 34 +++
 rtl/sd_slot_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_sd_slot_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the two-client SD sector channel arbiter.
package sd_arb_pkg;

    // Arbiter phases: wait for a client, present the command, run the
    // acknowledged transfer, then wait for the served client to let go.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } sd_arb_state_t;

    // Image slot numbers as seen by user_io.
    localparam logic SLOT_MMC   = 1'b0;
    localparam logic SLOT_NVRAM = 1'b1;

    // Direction of the latched command.
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } sd_arb_op_t;

    // One-hot slot mask used for sd_rd/sd_wr and the per-client error pulses.
    function automatic logic [1:0] slot_onehot(input logic slot);
        logic [1:0] mask;
        if (slot == SLOT_NVRAM) begin
            mask = 2'b10;
        end else begin
            mask = 2'b01;
        end
        return mask;
    endfunction

endpackage

// File: rtl/sd_slot_arbiter.sv
// Shares the user_io SD sector channel between the MMC emulation (slot 0)
// and the NVRAM save/restore client (slot 1). The winning command is latched
// and presented as a registered one-hot request; ack and buffer strobes are
// steered combinationally so they stay aligned with sd_buff_addr/sd_buff_dout.
// A watchdog aborts transfers that the ARM side never answers.
// TIMEOUT_W must be at least 2.
module sd_slot_arbiter
    import sd_arb_pkg::*;
#(
    parameter int TIMEOUT_W = 24
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic [31:0] c0_lba,
    input  logic        c0_rd,
    input  logic        c0_wr,
    output logic        c0_ack,
    output logic        c0_err,
    input  logic [7:0]  c0_buff_din,
    output logic        c0_buff_wr,

    input  logic [31:0] c1_lba,
    input  logic        c1_rd,
    input  logic        c1_wr,
    output logic        c1_ack,
    output logic        c1_err,
    input  logic [7:0]  c1_buff_din,
    output logic        c1_buff_wr,

    output logic [31:0] sd_lba,
    output logic [1:0]  sd_rd,
    output logic [1:0]  sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic        busy,
    output logic        grant
);

    // The watchdog fires on the (2^TIMEOUT_W - 1)th cycle spent waiting, i.e.
    // when the count of already-elapsed cycles reaches all-ones minus one.
    localparam logic [TIMEOUT_W-1:0] WD_ZERO = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    sd_arb_state_t        state_r;
    sd_arb_state_t        state_s;
    logic                 grant_r;
    logic                 grant_s;
    sd_arb_op_t           op_r;
    sd_arb_op_t           op_s;
    logic [31:0]          lba_r;
    logic [31:0]          lba_s;
    logic [TIMEOUT_W-1:0] wdog_r;
    logic [TIMEOUT_W-1:0] wdog_s;
    logic [1:0]           rd_r;
    logic [1:0]           rd_s;
    logic [1:0]           wr_r;
    logic [1:0]           wr_s;
    logic [1:0]           err_r;
    logic [1:0]           err_s;
    logic                 busy_r;

    logic                 req0_s;
    logic                 req1_s;
    logic                 win_s;
    logic                 win_rd_s;
    logic                 gnt_req_s;
    logic                 wd_expire_s;
    logic                 abort_s;
    logic                 active_s;

    // Request decode and round-robin pick: on a tie the client that was not
    // served last wins; a client asserting both rd and wr gets a read.
    always_comb begin
        req0_s = c0_rd | c0_wr;
        req1_s = c1_rd | c1_wr;
        if (req0_s && req1_s) begin
            win_s = ~grant_r;
        end else if (req1_s) begin
            win_s = SLOT_NVRAM;
        end else begin
            win_s = SLOT_MMC;
        end
        if (win_s == SLOT_NVRAM) begin
            win_rd_s = c1_rd;
        end else begin
            win_rd_s = c0_rd;
        end
        if (grant_r == SLOT_NVRAM) begin
            gnt_req_s = req1_s;
        end else begin
            gnt_req_s = req0_s;
        end
        wd_expire_s = (wdog_r >= WD_LAST);
    end

    // Next-state, command latch and watchdog update.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        op_s    = op_r;
        lba_s   = lba_r;
        wdog_s  = wdog_r;
        abort_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_s || req1_s) begin
                    state_s = ISSUE;
                    grant_s = win_s;
                    op_s    = win_rd_s ? OP_RD : OP_WR;
                    lba_s   = (win_s == SLOT_NVRAM) ? c1_lba : c0_lba;
                    wdog_s  = WD_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    state_s = XFER;
                    wdog_s  = WD_ZERO;
                end else if (wd_expire_s) begin
                    state_s = RELEASE;
                    abort_s = 1'b1;
                end else begin
                    wdog_s  = wdog_r + WD_ONE;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_s = RELEASE;
                end else if (wd_expire_s) begin
                    state_s = RELEASE;
                    abort_s = 1'b1;
                end else begin
                    wdog_s  = wdog_r + WD_ONE;
                end
            end
            RELEASE: begin
                // Hold here until the served client drops its level request so
                // a stale request is not granted a second time.
                if (!gnt_req_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next values of the registered request lines and error pulses.
    always_comb begin
        rd_s  = 2'b00;
        wr_s  = 2'b00;
        err_s = 2'b00;
        if (state_s == ISSUE) begin
            if (op_s == OP_RD) begin
                rd_s = slot_onehot(grant_s);
            end else begin
                wr_s = slot_onehot(grant_s);
            end
        end else begin
            rd_s = 2'b00;
            wr_s = 2'b00;
        end
        if (abort_s) begin
            err_s = slot_onehot(grant_r);
        end else begin
            err_s = 2'b00;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= SLOT_NVRAM;
            op_r    <= OP_RD;
            lba_r   <= 32'h0000_0000;
            wdog_r  <= WD_ZERO;
            rd_r    <= 2'b00;
            wr_r    <= 2'b00;
            err_r   <= 2'b00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            op_r    <= op_s;
            lba_r   <= lba_s;
            wdog_r  <= wdog_s;
            rd_r    <= rd_s;
            wr_r    <= wr_s;
            err_r   <= err_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Zero-latency steering of ack/strobe/data to the granted client only;
    // anything user_io sends while idle or releasing reaches nobody.
    always_comb begin
        active_s = (state_r == ISSUE) || (state_r == XFER);
        if (grant_r == SLOT_NVRAM) begin
            c0_ack      = 1'b0;
            c0_buff_wr  = 1'b0;
            c1_ack      = sd_ack & active_s;
            c1_buff_wr  = sd_buff_wr & active_s;
            sd_buff_din = c1_buff_din;
        end else begin
            c0_ack      = sd_ack & active_s;
            c0_buff_wr  = sd_buff_wr & active_s;
            c1_ack      = 1'b0;
            c1_buff_wr  = 1'b0;
            sd_buff_din = c0_buff_din;
        end
    end

    assign sd_lba = lba_r;
    assign sd_rd  = rd_r;
    assign sd_wr  = wr_r;
    assign busy   = busy_r;
    assign grant  = grant_r;
    assign c0_err = err_r[0];
    assign c1_err = err_r[1];

endmodule

// File: tb/tb_sd_slot_arbiter.sv
// Randomized scoreboard bench for sd_slot_arbiter. Stimulus predicts the
// service order from the round-robin rules and queues expected transfers;
// an independent monitor checks each issued command and its steering.
module tb_sd_slot_arbiter;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Main instance, default watchdog width.
    logic        reset;
    logic [31:0] c0_lba, c1_lba, sd_lba;
    logic        c0_rd, c0_wr, c0_ack, c0_err, c0_buff_wr;
    logic        c1_rd, c1_wr, c1_ack, c1_err, c1_buff_wr;
    logic [7:0]  c0_buff_din, c1_buff_din, sd_buff_din;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack, sd_buff_wr, busy, grant;

    // Short-watchdog instance for abort and reset scenarios.
    logic        t_reset;
    logic [31:0] t_c0_lba, t_c1_lba, t_sd_lba;
    logic        t_c0_rd, t_c0_wr, t_c0_ack, t_c0_err, t_c0_buff_wr;
    logic        t_c1_rd, t_c1_wr, t_c1_ack, t_c1_err, t_c1_buff_wr;
    logic [7:0]  t_c0_buff_din, t_c1_buff_din, t_sd_buff_din;
    logic [1:0]  t_sd_rd, t_sd_wr;
    logic        t_sd_ack, t_sd_buff_wr, t_busy, t_grant;

    sd_slot_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .c0_lba(c0_lba), .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_ack(c0_ack), .c0_err(c0_err),
        .c0_buff_din(c0_buff_din), .c0_buff_wr(c0_buff_wr),
        .c1_lba(c1_lba), .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_ack(c1_ack), .c1_err(c1_err),
        .c1_buff_din(c1_buff_din), .c1_buff_wr(c1_buff_wr),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .busy(busy), .grant(grant)
    );

    sd_slot_arbiter #(.TIMEOUT_W(4)) dut_t (
        .clk_sys(clk_sys), .reset(t_reset),
        .c0_lba(t_c0_lba), .c0_rd(t_c0_rd), .c0_wr(t_c0_wr), .c0_ack(t_c0_ack), .c0_err(t_c0_err),
        .c0_buff_din(t_c0_buff_din), .c0_buff_wr(t_c0_buff_wr),
        .c1_lba(t_c1_lba), .c1_rd(t_c1_rd), .c1_wr(t_c1_wr), .c1_ack(t_c1_ack), .c1_err(t_c1_err),
        .c1_buff_din(t_c1_buff_din), .c1_buff_wr(t_c1_buff_wr),
        .sd_lba(t_sd_lba), .sd_rd(t_sd_rd), .sd_wr(t_sd_wr), .sd_ack(t_sd_ack),
        .sd_buff_wr(t_sd_buff_wr), .sd_buff_din(t_sd_buff_din), .busy(t_busy), .grant(t_grant)
    );

    typedef struct {
        int          slot;
        bit          is_wr;
        logic [31:0] lba;
        logic [7:0]  din;
        int          nwr;
    } exp_t;

    exp_t exp_q[$];
    int   grant_m = 1;   // reference: slot served last
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // user_io responder for one transfer: ack lasts dur cycles with buffer
    // strobes on all but the first and last of them.
    task automatic serve(input int dly, input int dur);
        int t;
        t = 0;
        while ((sd_rd | sd_wr) == 2'b00 && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) chk("issue_wait_expired", 32'd0, 32'd1);
        repeat (dly) tick();
        for (int i = 0; i < dur; i++) begin
            sd_ack     = 1'b1;
            sd_buff_wr = (i >= 1) && (i <= dur - 2);
            if (i == 0) begin
                #1;
                if (c0_ack) begin c0_rd = 1'b0; c0_wr = 1'b0; end
                if (c1_ack) begin c1_rd = 1'b0; c1_wr = 1'b0; end
            end
            if (i == 1) chk("req_drop_after_ack", 32'(sd_rd | sd_wr), 32'd0);
            tick();
        end
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        t = 0;
        while (busy && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) chk("release_wait_expired", 32'd0, 32'd1);
    endtask

    // One round: requesting clients raise their commands together; the
    // reference decides the service order and queues the expected transfers.
    task automatic run_round(input bit r0, input bit r1, input logic [1:0] op0, input logic [1:0] op1,
                             input logic [31:0] l0, input logic [31:0] l1,
                             input logic [7:0] d0, input logic [7:0] d1, input int dur0, input int dur1);
        int   order[2];
        int   n;
        exp_t e;
        if (r0 && r1) begin
            order[0] = (grant_m == 1) ? 0 : 1;
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = r1 ? 1 : 0;
            order[1] = 0;
            n = 1;
        end
        grant_m = order[n-1];
        for (int i = 0; i < n; i++) begin
            e.slot  = order[i];
            e.is_wr = (order[i] == 1) ? !op1[1] : !op0[1];
            e.lba   = (order[i] == 1) ? l1 : l0;
            e.din   = (order[i] == 1) ? d1 : d0;
            e.nwr   = ((order[i] == 1) ? dur1 : dur0) - 2;
            exp_q.push_back(e);
        end
        c0_lba = l0; c1_lba = l1; c0_buff_din = d0; c1_buff_din = d1;
        c0_rd = r0 & op0[1]; c0_wr = r0 & op0[0];
        c1_rd = r1 & op1[1]; c1_wr = r1 & op1[0];
        tick();
        chk("grant_latency", 32'((sd_rd | sd_wr) != 2'b00), 32'd1);
        for (int i = 0; i < n; i++) serve(int'($urandom_range(0, 3)), (order[i] == 1) ? dur1 : dur0);
    endtask

    // Monitor / scoreboard for the main instance.
    exp_t       cur;
    bit         active = 1'b0;
    logic [1:0] prev_req = 2'b00;
    logic       prev_ack = 1'b0;
    int         cyc = 0;
    int         ack_fall_cyc = 0;
    int         n0 = 0;
    int         n1 = 0;

    initial begin
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (mon_en) begin
                if ((sd_rd | sd_wr) != 2'b00 && prev_req == 2'b00) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_issue", 32'(sd_rd | sd_wr), 32'd0);
                    end else begin
                        cur    = exp_q.pop_front();
                        active = 1'b1;
                        n0 = 0;
                        n1 = 0;
                        chk("issue_grant", 32'(grant), cur.slot);
                        chk("issue_rd", 32'(sd_rd), cur.is_wr ? 32'd0 : ((cur.slot == 1) ? 32'd2 : 32'd1));
                        chk("issue_wr", 32'(sd_wr), cur.is_wr ? ((cur.slot == 1) ? 32'd2 : 32'd1) : 32'd0);
                        chk("issue_lba", sd_lba, cur.lba);
                    end
                end
                if (active && !busy) begin
                    active = 1'b0;
                    chk("wr_strobes_granted", (cur.slot == 1) ? n1 : n0, cur.nwr);
                    chk("wr_strobes_other", (cur.slot == 1) ? n0 : n1, 32'd0);
                    chk("release_gap", cyc - ack_fall_cyc, 32'd2);
                end
                if (active) begin
                    if (c0_buff_wr) n0++;
                    if (c1_buff_wr) n1++;
                    if (sd_ack) begin
                        chk("ack_route", 32'({c1_ack, c0_ack}), (cur.slot == 1) ? 32'd2 : 32'd1);
                        chk("buff_din", 32'(sd_buff_din), 32'(cur.din));
                    end
                    if (sd_buff_wr) chk("buff_wr_route", 32'({c1_buff_wr, c0_buff_wr}), (cur.slot == 1) ? 32'd2 : 32'd1);
                    if (prev_ack && !sd_ack) ack_fall_cyc = cyc;
                end else if (sd_ack || sd_buff_wr) begin
                    chk("idle_gate", 32'({c1_ack, c0_ack, c1_buff_wr, c0_buff_wr}), 32'd0);
                end
                if (c0_err || c1_err) chk("spurious_err", 32'({c1_err, c0_err}), 32'd0);
            end
            prev_req = sd_rd | sd_wr;
            prev_ack = sd_ack;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not complete, got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k;
        int who;
        reset = 1'b1; t_reset = 1'b1;
        c0_lba = 32'd0; c1_lba = 32'd0; c0_rd = 1'b0; c0_wr = 1'b0; c1_rd = 1'b0; c1_wr = 1'b0;
        c0_buff_din = 8'd0; c1_buff_din = 8'd0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        t_c0_lba = 32'd0; t_c1_lba = 32'd0; t_c0_rd = 1'b0; t_c0_wr = 1'b0; t_c1_rd = 1'b0; t_c1_wr = 1'b0;
        t_c0_buff_din = 8'd0; t_c1_buff_din = 8'd0; t_sd_ack = 1'b0; t_sd_buff_wr = 1'b0;
        repeat (3) tick();
        reset = 1'b0; t_reset = 1'b0;
        tick();

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_sd_wr", 32'(sd_wr), 32'd0);
        chk("rst_sd_lba", sd_lba, 32'd0);
        chk("rst_grant", 32'(grant), 32'd1);
        chk("rst_err", 32'({c1_err, c0_err}), 32'd0);

        mon_en = 1'b1;
        // Tie after reset (client 0 first), repeated; long read; steering; rd+wr.
        run_round(1'b1, 1'b1, 2'b01, 2'b10, 32'h0000_0100, 32'h0000_0200, 8'h11, 8'h22, 4, 5);
        run_round(1'b1, 1'b1, 2'b01, 2'b10, 32'h0000_0300, 32'h0000_0400, 8'h33, 8'h44, 3, 6);
        run_round(1'b1, 1'b0, 2'b10, 2'b00, 32'h0000_1234, 32'h0000_0000, 8'h00, 8'h00, 514, 2);
        run_round(1'b0, 1'b1, 2'b00, 2'b01, 32'h0000_0000, 32'hABCD_0001, 8'h5A, 8'hA5, 6, 8);
        run_round(1'b0, 1'b1, 2'b00, 2'b11, 32'h0000_0000, 32'h0000_0777, 8'h5A, 8'hA5, 6, 4);

        for (int r = 0; r < 40; r++) begin
            who = int'($urandom_range(1, 3));
            sd_ack     = 1'($urandom_range(0, 1));
            sd_buff_wr = 1'($urandom_range(0, 1));
            tick();
            sd_ack     = 1'b0;
            sd_buff_wr = 1'b0;
            tick();
            run_round(who[0], who[1], 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)),
                      $urandom, $urandom, 8'($urandom), 8'($urandom),
                      int'($urandom_range(2, 12)), int'($urandom_range(2, 12)));
        end
        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Watchdog abort while waiting for ack.
        t_c0_lba = 32'h0000_0055; t_c0_rd = 1'b1;
        tick();
        k = 0;
        while (t_sd_rd != 2'b00 && k < 40) begin k++; tick(); end
        chk("to_issue_cycles", k, 32'd15);
        chk("to_err0_on", 32'(t_c0_err), 32'd1);
        chk("to_err1_quiet", 32'(t_c1_err), 32'd0);
        chk("to_busy_release", 32'(t_busy), 32'd1);
        tick();
        chk("to_err0_pulse", 32'(t_c0_err), 32'd0);
        repeat (4) tick();
        chk("to_hold_release", 32'(t_busy), 32'd1);
        chk("to_no_reissue", 32'(t_sd_rd | t_sd_wr), 32'd0);
        t_c0_rd = 1'b0;
        tick();
        chk("to_release_exit", 32'(t_busy), 32'd0);

        // Watchdog abort with ack stuck high, plus data/strobe steering to client 1.
        t_c1_lba = 32'h0000_0099; t_c1_wr = 1'b1; t_c0_buff_din = 8'h3C; t_c1_buff_din = 8'hC3;
        tick();
        chk("to_xfer_issue", 32'(t_sd_wr), 32'd2);
        t_sd_ack = 1'b1; t_sd_buff_wr = 1'b1;
        #1;
        chk("to_xfer_ack", 32'(t_c1_ack), 32'd1);
        chk("to_buff_wr_route", 32'({t_c1_buff_wr, t_c0_buff_wr}), 32'd2);
        chk("to_buff_din", 32'(t_sd_buff_din), 32'hC3);
        t_c1_wr = 1'b0;
        k = 0;
        while (!t_c1_err && k < 40) begin tick(); k++; end
        chk("to_xfer_cycles", k, 32'd16);
        chk("to_xfer_gated", 32'(t_c1_ack), 32'd0);
        t_sd_ack = 1'b0; t_sd_buff_wr = 1'b0;
        tick();
        chk("to_xfer_idle", 32'(t_busy), 32'd0);

        // Reset in the middle of a transfer, then a normal grant.
        t_c0_lba = 32'h0000_0077; t_c0_rd = 1'b1;
        tick();
        t_sd_ack = 1'b1;
        #1;
        t_c0_rd = 1'b0;
        tick();
        chk("rst_mid_busy_before", 32'(t_busy), 32'd1);
        t_reset = 1'b1;
        tick();
        chk("rst_mid_busy", 32'(t_busy), 32'd0);
        chk("rst_mid_sd_rd", 32'(t_sd_rd), 32'd0);
        chk("rst_mid_ack_gated", 32'(t_c0_ack), 32'd0);
        chk("rst_mid_grant", 32'(t_grant), 32'd1);
        chk("rst_mid_lba", t_sd_lba, 32'd0);
        t_reset = 1'b0; t_sd_ack = 1'b0;
        t_c1_lba = 32'h0000_1357; t_c1_rd = 1'b1;
        tick();
        chk("rst_regrant_rd", 32'(t_sd_rd), 32'd2);
        chk("rst_regrant_lba", t_sd_lba, 32'h0000_1357);
        t_sd_ack = 1'b1;
        #1;
        t_c1_rd = 1'b0;
        tick();
        t_sd_ack = 1'b0;
        tick();
        tick();
        chk("rst_regrant_done", 32'(t_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
